// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD read ports, two write ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports and mask their busy bits.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr0_en;
  logic              wr1_en;
  logic              iss_en;

  // Entry 0 is immune to writes and issue when it is the hardwired zero register.
  assign wr0_en = we0 && !(ZERO_REG != 0 && waddr0 == '0);
  assign wr1_en = we1 && !(ZERO_REG != 0 && waddr1 == '0);
  assign iss_en = iss_valid && !(ZERO_REG != 0 && iss_addr == '0);

  // Set is applied last so a new producer supersedes a retiring one on the same entry.
  always_comb begin
    busy_d = busy_q;
    if (wr0_en) busy_d[waddr0] = 1'b0;
    if (wr1_en) busy_d[waddr1] = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr0_en) mem_q[waddr0] <= wdata0;
      if (wr1_en) mem_q[waddr1] <= wdata1;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    logic              bsy;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = mem_q[ra];
      bsy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (we1 && waddr1 == ra) begin
        val = wdata1;
        bsy = 1'b0;
      end else if (we0 && waddr0 == ra) begin
        val = wdata0;
        bsy = 1'b0;
      end
`endif
      if (ZERO_REG != 0 && ra == '0) val = '0;
      // Reset forces quiet outputs even while write inputs are still toggling.
      if (!rst) begin
        val = '0;
        bsy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = val;
    assign rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x32/2-port instance under random traffic, plus a 64-bit 4-port instance.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0 = 1'b0, we1 = 1'b0, iss_valid = 1'b0;
  logic [4:0]  waddr0 = '0, waddr1 = '0, iss_addr = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [31:0] busy_vec;

  logic [23:0]  rd_addr64 = '0;
  logic [255:0] rd_data64;
  logic [3:0]   rd_busy64;
  logic         we0_64 = 1'b0, we1_64 = 1'b0, iss_64 = 1'b0;
  logic [5:0]   waddr0_64 = '0, waddr1_64 = '0, iss_addr64 = '0;
  logic [63:0]  wdata0_64 = '0, wdata1_64 = '0;
  logic [63:0]  busy_vec64;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4), .ZERO_REG(0)) u_dut64 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr64), .rd_data(rd_data64), .rd_busy(rd_busy64),
    .we0(we0_64), .waddr0(waddr0_64), .wdata0(wdata0_64), .we1(we1_64), .waddr1(waddr1_64),
    .wdata1(wdata1_64), .iss_valid(iss_64), .iss_addr(iss_addr64), .busy_vec(busy_vec64)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  busy;
    logic [31:0] bvec;
  } exp_t;

  exp_t        exp_q[$];
  event        smp_ev;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] regs_m [32];
  logic        busy_m [32];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
    end
  endtask

  function automatic exp_t model_out();
    exp_t        e;
    int          a;
    logic [31:0] v;
    logic        b;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      a = int'(rd_addr[k*5 +: 5]);
      v = regs_m[a];
      b = busy_m[a];
`ifdef REGFILE_BYPASS_EN
      if (we1 && int'(waddr1) == a) begin
        v = wdata1; b = 1'b0;
      end else if (we0 && int'(waddr0) == a) begin
        v = wdata0; b = 1'b0;
      end
`endif
      if (a == 0 || !rst) v = '0;
      if (!rst) b = 1'b0;
      e.data[k*32 +: 32] = v;
      e.busy[k] = b;
    end
    for (int i = 0; i < 32; i++) e.bvec[i] = busy_m[i];
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      regs_m[i] = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  task automatic update_model();
    if (!rst) return;
    if (we0 && waddr0 != 0) regs_m[waddr0] = wdata0;
    if (we1 && waddr1 != 0) regs_m[waddr1] = wdata1;
    if (we0) busy_m[waddr0] = 1'b0;
    if (we1) busy_m[waddr1] = 1'b0;
    if (iss_valid && iss_addr != 0) busy_m[iss_addr] = 1'b1;
  endtask

  task automatic step(input bit w0, input int a0, input logic [31:0] d0,
                      input bit w1, input int a1, input logic [31:0] d1,
                      input bit iv, input int ia, input int r0, input int r1);
    @(negedge clk);
    we0 = w0; waddr0 = 5'(a0); wdata0 = d0;
    we1 = w1; waddr1 = 5'(a1); wdata1 = d1;
    iss_valid = iv; iss_addr = 5'(ia);
    rd_addr = {5'(r1), 5'(r0)};
    exp_q.push_back(model_out());
    -> smp_ev;
    update_model();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    clear_model();
    exp_q.push_back(model_out());
    -> smp_ev;
  endtask

  task automatic release_reset();
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    rst = 1'b1;
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(smp_ev);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue expected an entry", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 256'(rd_data), 256'(e.data));
        chk("rd_busy", 256'(rd_busy), 256'(e.busy));
        chk("busy_vec", 256'(busy_vec), 256'(e.bvec));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    clear_model();
    // Held in reset with live write traffic: outputs must stay zero.
    step(1, 5, 32'h1111_1111, 1, 6, 32'h2222_2222, 1, 5, 5, 6);
    release_reset();

    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 5, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4, 6);

    step(1, 7, 32'hAAAA_0000, 1, 7, 32'h5555_FFFF, 0, 0, 7, 7);
    step(1, 3, 32'h0000_0033, 1, 4, 32'h0000_0044, 0, 0, 7, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);

    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 1);
    step(0, 0, 0, 1, 9, 32'h9999_0009, 0, 0, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    step(1, 9, 32'h0909_0909, 0, 0, 0, 1, 9, 9, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

    step(1, 12, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 12, 12);
    step(0, 0, 0, 0, 0, 0, 0, 0, 12, 12);

    // Mid-run asynchronous reset, then zero-register behaviour.
    async_reset();
    step(1, 5, 32'h5A5A_5A5A, 0, 0, 0, 1, 3, 5, 7);
    release_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    step(1, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 1500; n++) begin
      step(bit'($urandom_range(0, 1)), rnd_addr(), $urandom,
           bit'($urandom_range(0, 1)), rnd_addr(), $urandom,
           bit'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Wide configuration: no zero register, four read ports.
    @(negedge clk);
    we0_64 = 1'b1; waddr0_64 = 6'd63; wdata0_64 = 64'h0123_4567_89AB_CDEF;
    we1_64 = 1'b1; waddr1_64 = 6'd0;  wdata1_64 = 64'h1;
    @(negedge clk);
    we0_64 = 1'b0; we1_64 = 1'b0;
    rd_addr64 = {4{6'd63}};
    #1;
    chk("wide_r63", rd_data64, {4{64'h0123_4567_89AB_CDEF}});
    rd_addr64 = {6'd0, 6'd63, 6'd0, 6'd62};
    #1;
    chk("wide_r0_mix", rd_data64, {64'h1, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h0});
    @(negedge clk);
    iss_64 = 1'b1; iss_addr64 = 6'd0;
    @(negedge clk);
    iss_64 = 1'b0;
    rd_addr64 = {6'd1, 6'd0, 6'd0, 6'd0};
    #1;
    chk("wide_busy_vec", 256'(busy_vec64), 256'(64'h1));
    chk("wide_rd_busy", 256'(rd_busy64), 256'(4'b0111));

    #3;
    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
